pll_clk_sequencer: RTL and testbench

- Consumer side of the system PLL: takes the asynchronous `locked` from the 28.636363/14.318181 MHz PLL and drives the PLL reset with timeout and retry.
- Holds the core in reset until lock has been stable for a settle period.
- Generates the Apple II clock-enable pattern from the 28.636363 MHz clock: 14M, 7M, and the phi0 CPU cycle with the 65th-cycle stretch.
- Sits between the PLL instance and the emulator core.

---
 rtl/pll_clk_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_clk_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_sequencer.sv
// pll_clk_sequencer: PLL reset/lock sequencing and Apple II clock enables.
// Ports: clk (28.636 MHz), rst (sync, active-high), pll_locked (async);
//        pll_rst, core_rst (registered resets), ce_14m, ce_7m, ce_phi0,
//        long_cycle (clock enables, RUN only), retry_cnt (timeout retries).
module pll_clk_sequencer #(
    parameter int unsigned PLL_RST_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT    = 1048576,
    parameter int unsigned SETTLE_CYCLES   = 1024,
    parameter int unsigned CYCLES_PER_LINE = 65
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ce_14m,
    output logic       ce_7m,
    output logic       ce_phi0,
    output logic       long_cycle,
    output logic [3:0] retry_cnt
);

    typedef enum logic [1:0] {
        S_PLLRST,
        S_WAIT,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t      state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [3:0]  retry_n;
    logic [1:0]  div, div_n;
    logic [4:0]  cyc, cyc_n;
    logic [6:0]  line, line_n;
    logic        sync1, lk;
    logic        run, stretch, last;

    assign run     = (state == S_RUN);
    // Last CPU cycle of the line is stretched from 14 to 16 14M ticks.
    assign stretch = (line == 7'(CYCLES_PER_LINE - 1));
    assign last    = (cyc == (stretch ? 5'd31 : 5'd27));

    assign ce_14m     = run & div[0];
    assign ce_7m      = run & (div == 2'd3);
    assign ce_phi0    = run & last;
    assign long_cycle = run & stretch;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry_cnt;
        div_n   = '0;
        cyc_n   = '0;
        line_n  = '0;
        unique case (state)
            S_PLLRST: begin
                if (cnt == 32'(PLL_RST_CYCLES - 1)) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_WAIT: begin
                // Lock seen on the timeout cycle wins over the retry.
                if (lk) begin
                    state_n = S_SETTLE;
                    cnt_n   = '0;
                end else if (cnt == 32'(LOCK_TIMEOUT - 1)) begin
                    state_n = S_PLLRST;
                    cnt_n   = '0;
                    if (retry_cnt != 4'hf)
                        retry_n = retry_cnt + 4'd1;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_SETTLE: begin
                if (!lk) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else if (cnt == 32'(SETTLE_CYCLES - 1)) begin
                    state_n = S_RUN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_RUN: begin
                // Lock loss abandons the current CPU cycle; the zero
                // defaults restart div/cyc/line on the next RUN entry.
                if (!lk) begin
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end else begin
                    div_n  = div + 2'd1;
                    cyc_n  = last ? 5'd0 : cyc + 5'd1;
                    line_n = line;
                    if (last)
                        line_n = stretch ? 7'd0 : line + 7'd1;
                end
            end
            default: begin
                state_n = S_PLLRST;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_PLLRST;
            cnt       <= '0;
            retry_cnt <= '0;
            div       <= '0;
            cyc       <= '0;
            line      <= '0;
            sync1     <= 1'b0;
            lk        <= 1'b0;
            pll_rst   <= 1'b1;
            core_rst  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            retry_cnt <= retry_n;
            div       <= div_n;
            cyc       <= cyc_n;
            line      <= line_n;
            sync1     <= pll_locked;
            lk        <= sync1;
            pll_rst   <= (state_n == S_PLLRST);
            core_rst  <= (state_n != S_RUN);
        end
    end

endmodule

// File: tb/tb_pll_clk_sequencer.sv
// tb_pll_clk_sequencer: directed vectors plus corner-case sequences
// for pll_clk_sequencer (PLL_RST=4, TIMEOUT=10, SETTLE=8, 65 cyc/line).
module tb_pll_clk_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst, core_rst;
    logic       ce_14m, ce_7m, ce_phi0, long_cycle;
    logic [3:0] retry_cnt;

    int n_vec = 0;
    int n_err = 0;

    pll_clk_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (10),
        .SETTLE_CYCLES  (8),
        .CYCLES_PER_LINE(65)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .core_rst  (core_rst),
        .ce_14m    (ce_14m),
        .ce_7m     (ce_7m),
        .ce_phi0   (ce_phi0),
        .long_cycle(long_cycle),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic lock;
        logic pll_rst;
        logic core_rst;
        logic ce14;
        logic ce7;
        logic phi0;
        logic lng;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ce_14m"}, int'(ce_14m), 0);
        chk({tag, ".ce_7m"}, int'(ce_7m), 0);
        chk({tag, ".ce_phi0"}, int'(ce_phi0), 0);
        chk({tag, ".long"}, int'(long_cycle), 0);
    endtask

    // Reference timing: k clks since RUN entry, line = 64*28 + 32 clks.
    task automatic chk_run(input int k);
        int p;
        p = k % 1824;
        chk("run.core_rst", int'(core_rst), 0);
        chk("run.ce_14m", int'(ce_14m), int'(k % 2 == 1));
        chk("run.ce_7m", int'(ce_7m), int'(k % 4 == 3));
        chk("run.ce_phi0", int'(ce_phi0),
            (p < 1792) ? int'(p % 28 == 27) : int'(p == 1823));
        chk("run.long", int'(long_cycle), int'(p >= 1792));
    endtask

    function automatic vec_t mk(logic r, logic l, logic pr, logic cr,
                                logic c14, logic c7, logic ph, logic lg);
        vec_t v;
        v.rst = r; v.lock = l; v.pll_rst = pr; v.core_rst = cr;
        v.ce14 = c14; v.ce7 = c7; v.phi0 = ph; v.lng = lg;
        return v;
    endfunction

    initial begin
        int n14, n7, nph;
        rst        = 1'b1;
        pll_locked = 1'b1;

        // Startup with lock already present: 3 reset clks, PLLRST 4,
        // WAIT 1, SETTLE 8, then RUN with the first div steps.
        for (int i = 0; i < 3; i++)
            tbl[i] = mk(1, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 3; i < 6; i++)
            tbl[i] = mk(0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 6; i < 15; i++)
            tbl[i] = mk(0, 1, 0, 1, 0, 0, 0, 0);
        tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 0, 0, 1, 0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0, 1, 1, 0, 0);
        tbl[19] = mk(0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rst        = tbl[i].rst;
            pll_locked = tbl[i].lock;
            tick();
            chk("tbl.pll_rst", int'(pll_rst), int'(tbl[i].pll_rst));
            chk("tbl.core_rst", int'(core_rst), int'(tbl[i].core_rst));
            chk("tbl.ce_14m", int'(ce_14m), int'(tbl[i].ce14));
            chk("tbl.ce_7m", int'(ce_7m), int'(tbl[i].ce7));
            chk("tbl.ce_phi0", int'(ce_phi0), int'(tbl[i].phi0));
            chk("tbl.long", int'(long_cycle), int'(tbl[i].lng));
            chk("tbl.retry", int'(retry_cnt), 0);
        end

        // Two full lines of RUN; counts checked over the second line.
        n14 = 0; n7 = 0; nph = 0;
        for (int k = 5; k < 3648; k++) begin
            tick();
            chk_run(k);
            if (k >= 1824) begin
                n14 += int'(ce_14m);
                n7  += int'(ce_7m);
                nph += int'(ce_phi0);
            end
        end
        chk("line.n_14m", n14, 912);
        chk("line.n_7m", n7, 456);
        chk("line.n_phi0", nph, 65);

        // Lock loss at cyc=10: lk falls 2 clks later, FSM leaves RUN on
        // the third edge.
        for (int k = 3648; k <= 3658; k++) begin
            tick();
            chk_run(k);
        end
        pll_locked = 1'b0;
        tick(); chk_run(3659);
        tick(); chk_run(3660);
        tick();
        chk("loss.core_rst", int'(core_rst), 1);
        chk("loss.pll_rst", int'(pll_rst), 0);
        chk_idle("loss");
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("loss.hold_core", int'(core_rst), 1);
            chk("loss.hold_pll", int'(pll_rst), 0);
        end

        // Relock: 2 sync + WAIT exit + 8 SETTLE -> RUN on edge 11.
        pll_locked = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("relock.core_rst", int'(core_rst), 1);
            chk_idle("relock");
        end
        tick();
        chk_run(0);
        for (int k = 1; k < 1796; k++) begin
            tick();
            chk_run(k);
        end

        // Reset in the stretched line-64 cycle.
        rst = 1'b1;
        tick();
        chk("rst.pll_rst", int'(pll_rst), 1);
        chk("rst.core_rst", int'(core_rst), 1);
        chk("rst.retry", int'(retry_cnt), 0);
        chk_idle("rst");
        tick();
        tick();

        // Lock glitch seen by the FSM at SETTLE count 5.
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            pll_locked = (i != 8);
            tick();
            chk("glitch.core_rst", int'(core_rst), int'(i < 19));
            chk("glitch.pll_rst", int'(pll_rst), int'(i < 3));
        end

        // No lock ever: pll_rst period 4+10, retry saturates at 15.
        rst        = 1'b1;
        pll_locked = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int t = 1; t <= 238; t++) begin
            tick();
            chk("tmo.pll_rst", int'(pll_rst), int'(t % 14 < 4));
            chk("tmo.retry", int'(retry_cnt),
                (t / 14 > 15) ? 15 : t / 14);
            chk("tmo.core_rst", int'(core_rst), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
